// File: rtl/char_segmenter.sv
// Frame-level glyph segmentation: builds a column-occupancy map of the ROI during the frame,
// then scans it once per frame and publishes up to MAX_SEG horizontal runs plus the common y extent.
module char_segmenter #(
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 720,
    parameter int ROI_Y0   = 200,
    parameter int ROI_Y1   = 520,
    parameter int MIN_W    = 4,
    parameter int MAX_SEG  = 3
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_vde,
    input  logic [10:0]             i_set_x,
    input  logic [9:0]              i_set_y,
    input  logic                    i_data_bin,
    output logic                    o_seg_valid,
    output logic [1:0]              o_seg_count,
    output logic [11*MAX_SEG-1:0]   o_seg_x0,
    output logic [11*MAX_SEG-1:0]   o_seg_x1,
    output logic [9:0]              o_seg_y0,
    output logic [9:0]              o_seg_y1,
    output logic                    o_overflow,
    output logic                    o_busy
);

    localparam int          XW      = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam logic [10:0] LAST_X  = 11'(H_ACTIVE - 1);
    localparam logic [9:0]  LAST_Y  = 10'(V_ACTIVE - 1);
    localparam logic [11:0] X_LIM   = 12'(H_ACTIVE);
    localparam logic [9:0]  ROI_LO  = 10'(ROI_Y0);
    localparam logic [9:0]  ROI_HI  = 10'(ROI_Y1);
    localparam logic [10:0] MIN_M1  = 11'(MIN_W - 1);
    localparam logic [1:0]  MAX_CNT = 2'(MAX_SEG);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        SCAN    = 2'd2,
        PUBLISH = 2'd3
    } state_t;

    state_t state, state_n;

    logic [H_ACTIVE-1:0] col_map;
    logic [9:0]          ymin, ymax;

    logic [10:0]         scan_c;
    logic                in_run;
    logic [10:0]         run_x0;
    logic [1:0]          cnt, cnt_n;
    logic                ovf, ovf_n;
    logic [10:0]         sx0   [MAX_SEG];
    logic [10:0]         sx1   [MAX_SEG];
    logic [10:0]         sx0_n [MAX_SEG];
    logic [10:0]         sx1_n [MAX_SEG];

    logic                frame_start, last_pix, ink, start_pix, scan_last;
    logic [XW-1:0]       map_idx;
    logic                scan_bit, at_last, close_run, keep_run;
    logic [10:0]         close_x0, close_x1;

    assign frame_start = i_vde && (i_set_x == 11'd0) && (i_set_y == 10'd0);
    assign last_pix    = i_vde && (i_set_x == LAST_X) && (i_set_y == LAST_Y);
    assign ink         = i_vde && i_data_bin && ({1'b0, i_set_x} < X_LIM)
                         && (i_set_y >= ROI_LO) && (i_set_y <= ROI_HI);
    // A frame start in IDLE arms the block; a frame start in ACCUM restarts it.
    assign start_pix   = ((state == IDLE) || (state == ACCUM)) && frame_start;
    assign scan_last   = (state == SCAN) && (scan_c == LAST_X);
    assign map_idx     = i_set_x[XW-1:0];
    assign o_busy      = (state == SCAN) || (state == PUBLISH);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (frame_start) state_n = ACCUM;
            ACCUM:   if (last_pix && !frame_start) state_n = SCAN;
            SCAN:    if (scan_c == LAST_X) state_n = PUBLISH;
            PUBLISH: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // The scan consumes map[0] and shifts right, so the map is empty when the scan ends.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            col_map <= '0;
        end else if (start_pix) begin
            col_map <= '0;
            if (ink) col_map[map_idx] <= 1'b1;
        end else if ((state == ACCUM) && ink) begin
            col_map[map_idx] <= 1'b1;
        end else if (state == SCAN) begin
            col_map <= col_map >> 1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            ymin <= '1;
            ymax <= '0;
        end else if (start_pix) begin
            ymin <= ink ? i_set_y : '1;
            ymax <= ink ? i_set_y : '0;
        end else if ((state == ACCUM) && ink) begin
            if (i_set_y < ymin) ymin <= i_set_y;
            if (i_set_y > ymax) ymax <= i_set_y;
        end else if (state == PUBLISH) begin
            ymin <= '1;
            ymax <= '0;
        end
    end

    // Run detection for the column currently at map[0]; a run open at the last column closes there.
    always_comb begin
        scan_bit  = col_map[0];
        at_last   = (scan_c == LAST_X);
        close_x0  = in_run ? run_x0 : scan_c;
        close_x1  = scan_bit ? scan_c : (scan_c - 11'd1);
        close_run = (state == SCAN) && ((in_run && !scan_bit) || (scan_bit && at_last));
        keep_run  = close_run && ((close_x1 - close_x0) >= MIN_M1);
        cnt_n     = cnt;
        ovf_n     = ovf;
        sx0_n     = sx0;
        sx1_n     = sx1;
        if (keep_run) begin
            if (cnt < MAX_CNT) begin
                for (int k = 0; k < MAX_SEG; k++) begin
                    if (cnt == 2'(k)) begin
                        sx0_n[k] = close_x0;
                        sx1_n[k] = close_x1;
                    end
                end
                cnt_n = cnt + 2'd1;
            end else begin
                ovf_n = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            scan_c <= '0;
            in_run <= 1'b0;
            run_x0 <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
            for (int k = 0; k < MAX_SEG; k++) begin
                sx0[k] <= '0;
                sx1[k] <= '0;
            end
        end else if ((state == ACCUM) && last_pix && !frame_start) begin
            scan_c <= '0;
            in_run <= 1'b0;
            run_x0 <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
            for (int k = 0; k < MAX_SEG; k++) begin
                sx0[k] <= '0;
                sx1[k] <= '0;
            end
        end else if (state == SCAN) begin
            scan_c <= scan_c + 11'd1;
            in_run <= scan_bit && !at_last;
            if (scan_bit && !in_run) run_x0 <= scan_c;
            cnt    <= cnt_n;
            ovf    <= ovf_n;
            sx0    <= sx0_n;
            sx1    <= sx1_n;
        end
    end

    // Results load on the final scan edge so they are already valid in the PUBLISH cycle.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_seg_valid <= 1'b0;
            o_seg_count <= '0;
            o_seg_x0    <= '0;
            o_seg_x1    <= '0;
            o_seg_y0    <= '0;
            o_seg_y1    <= '0;
            o_overflow  <= 1'b0;
        end else begin
            o_seg_valid <= scan_last;
            if (scan_last) begin
                o_seg_count <= cnt_n;
                o_overflow  <= ovf_n;
                for (int k = 0; k < MAX_SEG; k++) begin
                    o_seg_x0[11*k +: 11] <= sx0_n[k];
                    o_seg_x1[11*k +: 11] <= sx1_n[k];
                end
                if (ymin <= ymax) begin
                    o_seg_y0 <= ymin;
                    o_seg_y1 <= ymax;
                end else begin
                    o_seg_y0 <= '0;
                    o_seg_y1 <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_char_segmenter.sv
// Scoreboard bench for char_segmenter on a 64x16 frame: frames are driven from a driver task,
// expected publishes are queued up front and a monitor pops and compares on every o_seg_valid.
module tb_char_segmenter;

    localparam int H  = 64;
    localparam int V  = 16;
    localparam int EW = 89;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vde = 1'b0;
    logic [10:0] sx = '0;
    logic [9:0]  sy = '0;
    logic        bin = 1'b0;

    logic        seg_valid;
    logic [1:0]  seg_count;
    logic [32:0] seg_x0, seg_x1;
    logic [9:0]  seg_y0, seg_y1;
    logic        overflow, busy;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [EW-1:0] exp_q[$];
    int            lat_q[$];

    char_segmenter #(
        .H_ACTIVE(H), .V_ACTIVE(V), .ROI_Y0(4), .ROI_Y1(11), .MIN_W(3), .MAX_SEG(3)
    ) dut (
        .i_clk(clk), .i_rst(rst_n), .i_vde(vde), .i_set_x(sx), .i_set_y(sy),
        .i_data_bin(bin), .o_seg_valid(seg_valid), .o_seg_count(seg_count),
        .o_seg_x0(seg_x0), .o_seg_x1(seg_x1), .o_seg_y0(seg_y0), .o_seg_y1(seg_y1),
        .o_overflow(overflow), .o_busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    function automatic logic [EW-1:0] mk(input int cnt, input int a0, input int a1,
                                         input int b0, input int b1, input int c0,
                                         input int c1, input int y0, input int y1,
                                         input int ovf);
        logic [32:0] x0, x1;
        x0 = {11'(c0), 11'(b0), 11'(a0)};
        x1 = {11'(c1), 11'(b1), 11'(a1)};
        return {2'(cnt), x0, x1, 10'(y0), 10'(y1), 1'(ovf)};
    endfunction

    // One full frame: 64 active + 8 blank per line, 100 blank cycles after the frame.
    // With rst_mid set, reset is pulsed while the block is scanning.
    task automatic drive_frame(input logic [63:0] cols, input logic [15:0] rows,
                               input bit expect_pub, input bit rst_mid);
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                @(negedge clk);
                vde = 1'b1;
                sx  = 11'(x);
                sy  = 10'(y);
                bin = cols[x] & rows[y];
                if (expect_pub && (x == H - 1) && (y == V - 1)) lat_q.push_back(cyc + H + 1);
            end
            repeat (8) begin
                @(negedge clk);
                vde = 1'b0;
                bin = 1'b0;
            end
        end
        if (rst_mid) begin
            check("busy_in_scan", 64'(busy), 64'd1);
            rst_n = 1'b0;
            #1;
            check("midscan_rst_valid", 64'(seg_valid), 64'd0);
            check("midscan_rst_count", 64'(seg_count), 64'd0);
            check("midscan_rst_x0", 64'(seg_x0), 64'd0);
            check("midscan_rst_x1", 64'(seg_x1), 64'd0);
            check("midscan_rst_y", 64'({seg_y0, seg_y1}), 64'd0);
            check("midscan_rst_busy", 64'(busy), 64'd0);
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
        end
        repeat (100) begin
            @(negedge clk);
            vde = 1'b0;
            bin = 1'b0;
        end
    endtask

    // Monitor: every publish must match the oldest queued expectation.
    initial begin
        logic [EW-1:0] e;
        bit prev_valid;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_valid) check("valid_pulse_width", 64'(seg_valid), 64'd0);
            if (seg_valid) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_valid: got publish at cycle %0d expected none", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("count", 64'(seg_count), 64'(e[88:87]));
                    check("x0", 64'(seg_x0), 64'(e[86:54]));
                    check("x1", 64'(seg_x1), 64'(e[53:21]));
                    check("y0", 64'(seg_y0), 64'(e[20:11]));
                    check("y1", 64'(seg_y1), 64'(e[10:1]));
                    check("overflow", 64'(overflow), 64'(e[0]));
                    if (lat_q.size() != 0) check("latency", 64'(cyc), 64'(lat_q.pop_front()));
                end
            end
            prev_valid = seg_valid;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of run expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        repeat (3) @(negedge clk);
        check("rst_valid", 64'(seg_valid), 64'd0);
        check("rst_count", 64'(seg_count), 64'd0);
        check("rst_x0", 64'(seg_x0), 64'd0);
        check("rst_x1", 64'(seg_x1), 64'd0);
        check("rst_y0", 64'(seg_y0), 64'd0);
        check("rst_y1", 64'(seg_y1), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Blank frame
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        drive_frame(64'h0, 16'h0000, 1'b1, 1'b0);

        // Three runs 5-9, 20-22, 40-47 on rows 6-9
        exp_q.push_back(mk(3, 5, 9, 20, 22, 40, 47, 6, 9, 0));
        drive_frame(64'h0000_FF00_0070_03E0, 16'h03C0, 1'b1, 1'b0);

        // Narrow run 10-11 dropped, 30-35 kept, row 5
        exp_q.push_back(mk(1, 30, 35, 0, 0, 0, 0, 5, 5, 0));
        drive_frame(64'h0000_000F_C000_0C00, 16'h0020, 1'b1, 1'b0);

        // Four runs, last touching the right edge: overflow
        exp_q.push_back(mk(3, 2, 5, 12, 15, 30, 33, 4, 11, 1));
        drive_frame(64'hF000_0003_C000_F03C, 16'h0FF0, 1'b1, 1'b0);

        // Ink everywhere but only outside the ROI rows
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        drive_frame(64'hFFFF_FFFF_FFFF_FFFF, 16'hF00F, 1'b1, 1'b0);

        // Columns 50-55 on the first ROI row: map must be clean
        exp_q.push_back(mk(1, 50, 55, 0, 0, 0, 0, 4, 4, 0));
        drive_frame(64'h00FC_0000_0000_0000, 16'h0010, 1'b1, 1'b0);

        // Reset in the middle of the scan: no publish for this frame
        drive_frame(64'h0000_FF00_0070_03E0, 16'h03C0, 1'b0, 1'b1);

        // Following full frame publishes normally
        exp_q.push_back(mk(3, 5, 9, 20, 22, 40, 47, 6, 9, 0));
        drive_frame(64'h0000_FF00_0070_03E0, 16'h03C0, 1'b1, 1'b0);

        waited = 0;
        while ((exp_q.size() != 0) && (waited < 500)) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL publish_timeout: got %0d pending expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/char_segmenter.md
Name: char_segmenter

Overview:
- Frame-level segmentation stage between the binarizer and the recogniser.
- Consumes the per-pixel binary stream (data_bin) with its pixel coordinates and accumulates a column-occupancy map inside a vertical region of interest.
- After each frame, scans the map and publishes the horizontal extents of up to three glyph regions (num_1, sym, num_2 order, left to right), plus their common vertical extent.
- Recognition then samples fixed windows instead of scanning the whole frame.

Parameters:
- H_ACTIVE, 1280: active pixels per line.
- V_ACTIVE, 720: active lines per frame.
- ROI_Y0, 200: first line (inclusive) that contributes to the map.
- ROI_Y1, 520: last line (inclusive) that contributes to the map.
- MIN_W, 4: runs narrower than this (in columns) are discarded as noise.
- MAX_SEG, 3: number of segment slots.

Ports:
- i_clk, input, 1: pixel clock; all logic on rising edge.
- i_rst, input, 1: asynchronous, active-low reset.
- i_vde, input, 1: active-video qualifier for the current pixel.
- i_set_x, input, 11: pixel column.
- i_set_y, input, 10: pixel row.
- i_data_bin, input, 1: 1 = foreground (ink) pixel.
- o_seg_valid, output, 1: one-cycle pulse when new results are published.
- o_seg_count, output, 2: number of valid segments, 0..MAX_SEG.
- o_seg_x0, output, 33: packed left columns; slot k is bits [11k+10:11k].
- o_seg_x1, output, 33: packed right columns, inclusive, same packing.
- o_seg_y0, output, 10: topmost foreground row inside the ROI.
- o_seg_y1, output, 10: bottommost foreground row inside the ROI.
- o_overflow, output, 1: more than MAX_SEG qualifying runs in the last frame.
- o_busy, output, 1: high while in SCAN or PUBLISH.

Behaviour:
- Reset (i_rst=0, asynchronous):
  - All outputs 0.
  - Column map cleared, ymin=all-ones, ymax=0.
  - State goes to IDLE.
  - Reset mid-frame or mid-scan discards everything; the next full frame is required for results.
- States are IDLE, ACCUM, SCAN, PUBLISH.
- IDLE -> ACCUM on a sampled pixel with i_vde=1, x=0, y=0. That pixel is itself accumulated.
- ACCUM:
  - On each i_vde=1 pixel with i_data_bin=1, x<H_ACTIVE and ROI_Y0<=y<=ROI_Y1: set map[x]=1, ymin=min(ymin,y), ymax=max(ymax,y).
  - Pixels with i_vde=0 are ignored.
  - The pixel x=H_ACTIVE-1, y=V_ACTIVE-1 with i_vde=1 is accumulated, then the next cycle enters SCAN.
  - A new frame start seen in ACCUM (x=0, y=0, i_vde=1, not the first pixel) restarts accumulation: clear map and y trackers in that cycle, then accumulate that pixel.
- SCAN:
  - Column index c runs 0..H_ACTIVE-1, one column per clock, so it takes exactly H_ACTIVE cycles.
  - Each cycle reads map[c] and clears it to 0, so the map is clean for the next frame.
  - Run start: bit=1 while not in a run; record x0=c.
  - Run end: bit=0 while in a run gives x1=c-1. A run still open at c=H_ACTIVE-1 closes with x1=H_ACTIVE-1.
  - A closed run with width x1-x0+1 >= MIN_W is stored in the next free slot. When all slots are full, the run sets overflow and is dropped; the count saturates at MAX_SEG.
  - All input pixels are ignored during SCAN, even if i_vde asserts.
- PUBLISH (one cycle):
  - Output registers load: count, x0/x1 slots (unused slots = 0), overflow.
  - o_seg_y0/o_seg_y1 load ymin/ymax, or 0/0 if no foreground was seen.
  - o_seg_valid=1 for that single cycle.
  - ymin/ymax reset; next state IDLE.
- Latency: last pixel sampled in cycle N; SCAN occupies N+1..N+H_ACTIVE; o_seg_valid is high in cycle N+H_ACTIVE+1 and outputs are valid from that cycle.
- Outputs hold between publishes.
- A frame start arriving during SCAN/PUBLISH is missed; that frame yields no publish and the block re-arms on the following frame start.
- Runs touching column 0 start at x0=0.
- Slot order is strictly ascending x0.

Test Plan (bench uses H_ACTIVE=64, V_ACTIVE=16, ROI_Y0=4, ROI_Y1=11, MIN_W=3; full frames with 8 blanking cycles per line and 100 blanking cycles per frame):
- Blank frame, all i_data_bin=0 -> one o_seg_valid pulse at last-pixel+65 cycles; count=0, all x fields=0, y0=y1=0, overflow=0.
- Ink in columns 5-9, 20-22 and 40-47, rows 6-9 -> count=3; slots (5,9), (20,22), (40,47); y0=6, y1=9.
- Ink in columns 10-11 (width 2) and 30-35, rows 5-5 -> count=1; slot0=(30,35); y0=y1=5.
- Four runs at 2-5, 12-15, 30-33 and 60-63, with the last run touching the edge -> count=3, overflow=1; slots (2,5), (12,15), (30,33).
- Ink only in rows 0-3 and 12-15 (outside ROI) -> count=0, y0=y1=0. Then the next frame with ink at column 50-55, row 4 -> count=1 (50,55), proving the map was cleared.
- Assert i_rst low mid-SCAN -> all outputs 0 immediately, no o_seg_valid for that frame. The following full frame publishes normally.
